// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths for the cache-line to burst-memory adaptor.
package cacheline_adaptor_pkg;

   localparam int LINE_W   = 256;
   localparam int BURST_W  = 64;
   localparam int BEATS    = LINE_W / BURST_W;
   localparam int OFFSET_W = 5;
   localparam int CNT_W    = $clog2(BEATS);

   // Clear the byte offset so the burst always starts on a line boundary.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one whole-line read/write from the cache arbiter into a 4-beat
// burst on the 64-bit memory port. One transaction in flight, no queuing.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting; the only state where line requests are sampled
// S_READ  | mem_read_o high, capturing one beat per mem_resp_i
// S_WRITE | mem_write_o high, presenting the beat selected by the counter
// S_DONE  | line_resp_o pulse for one cycle, then back to S_IDLE
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        line_addr_i,
   input  logic [LINE_W-1:0]  line_wdata_i,
   input  logic               line_read_i,
   input  logic               line_write_i,
   output logic [LINE_W-1:0]  line_rdata_o,
   output logic               line_resp_o,
   output logic [31:0]        mem_addr_o,
   input  logic [BURST_W-1:0] mem_rdata_i,
   output logic [BURST_W-1:0] mem_wdata_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   input  logic               mem_resp_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_addr;
   logic [LINE_W-1:0]  r_wline;
   logic [LINE_W-1:0]  r_rline;
   logic               w_last_beat;

   assign w_last_beat = mem_resp_i && (r_cnt == CNT_W'(BEATS - 1));

   // State register; reset abandons any burst without signalling upstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; write takes priority when both requests are raised.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (line_write_i) begin
               w_next = S_WRITE;
            end else if (line_read_i) begin
               w_next = S_READ;
            end
         end
         S_READ: begin
            if (w_last_beat) begin
               w_next = S_DONE;
            end
         end
         S_WRITE: begin
            if (w_last_beat) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only, so no line_* input reaches mem_*.
   always_comb begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      line_resp_o = 1'b0;
      mem_wdata_o = '0;
      case (r_state)
         S_READ: begin
            mem_read_o = 1'b1;
         end
         S_WRITE: begin
            mem_write_o = 1'b1;
            mem_wdata_o = r_wline[BURST_W*r_cnt +: BURST_W];
         end
         S_DONE: begin
            line_resp_o = 1'b1;
         end
         default: begin
            mem_read_o = 1'b0;
         end
      endcase
   end

   // Datapath: latch request, count beats, assemble read line in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wline <= '0;
         r_rline <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (line_write_i) begin
                  r_addr  <= line_align(line_addr_i);
                  r_wline <= line_wdata_i;
                  r_cnt   <= '0;
               end else if (line_read_i) begin
                  r_addr  <= line_align(line_addr_i);
                  r_cnt   <= '0;
               end
            end
            S_READ: begin
               if (mem_resp_i) begin
                  r_rline[BURST_W*r_cnt +: BURST_W] <= mem_rdata_i;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               if (mem_resp_i) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign mem_addr_o   = r_addr;
   assign line_rdata_o = r_rline;

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache-line arbiter, between its 256-bit physical-memory port and the 64-bit burst DRAM model.
- Accepts one whole-line read or write from the arbiter and converts it into a 4-beat burst transaction on the memory side.
- For reads, it reassembles the line before responding. It carries one transaction at a time; there is no queuing.

Parameters:
- LINE_W, 256: cache line width in bits.
- BURST_W, 64: memory data-bus width in bits.
- BEATS, LINE_W/BURST_W (=4): beats per line. This is derived and must not be overridden independently.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- line_addr_i  in  32  line address from arbiter (pmem_address side).
- line_wdata_i  in  LINE_W  write line from arbiter.
- line_read_i  in  1  line read request; held high until line_resp_o.
- line_write_i  in  1  line write request; held high until line_resp_o.
- line_rdata_o  out  LINE_W  assembled read line.
- line_resp_o  out  1  one-cycle completion pulse.
- mem_addr_o  out  32  burst address, line-aligned.
- mem_rdata_i  in  BURST_W  read beat data.
- mem_wdata_o  out  BURST_W  write beat data.
- mem_read_o  out  1  burst read request.
- mem_write_o  out  1  burst write request.
- mem_resp_i  in  1  per-beat acknowledge.

Behaviour:
- Clock and reset: a single clock, clk. Reset (rst) is asynchronous and active-high.
- Reset values:
  - line_resp_o, mem_read_o and mem_write_o are 0.
  - line_rdata_o, mem_addr_o and mem_wdata_o are 0.
  - The beat counter is 0 and the state is IDLE.
- Reset mid-burst: the transaction is abandoned and nothing is signalled upstream. The memory model is reset by the same rst.
- States: IDLE, READ, WRITE, DONE. Outputs are registered or decoded from state; there is no combinational path from line_* inputs to mem_* outputs.
- IDLE:
  - Requests are sampled only in IDLE.
  - If line_write_i=1, latch the address and line_wdata_i, clear the counter, and go to WRITE. Write wins if both requests are high; that case is illegal, but the behaviour is defined.
  - Else if line_read_i=1, latch the address, clear the counter, and go to READ.
- Address: mem_addr_o = {latched_addr[31:5], 5'b0}, held constant through READ and WRITE.
- READ:
  - mem_read_o=1.
  - On each cycle with mem_resp_i=1, store mem_rdata_i into line bits [64*cnt +: 64] and increment cnt.
  - Beat 0 is the least significant. Gaps (mem_resp_i=0 between beats) are legal and stall the counter.
  - The 4th beat (cnt==3 with mem_resp_i) moves to DONE. mem_read_o drops in DONE.
- WRITE:
  - mem_write_o=1 and mem_wdata_o = latched line [64*cnt +: 64].
  - mem_resp_i=1 means the memory consumed the current beat; increment cnt.
  - The 4th acknowledge moves to DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle, then IDLE.
- Read data hold: line_rdata_o holds the last assembled read line until the next read's first beat overwrites it. A write never changes line_rdata_o.
- Latency:
  - Request in IDLE at cycle 0 puts mem_read_o/mem_write_o high at cycle 1.
  - With back-to-back beats at cycles k..k+3, line_resp_o is high at cycle k+4.
- Back-to-back: a request still high in the IDLE cycle immediately after DONE starts a new transaction. The arbiter drops its request after line_resp_o, so this only occurs for genuine new requests.
- Counter: 2 bits, wraps 3->0 only on the DONE transition.
- Stray acknowledges: mem_resp_i outside READ/WRITE is ignored.

Decomposition:
- Shared package (with rv32i_types): LINE_W, BURST_W, BEATS, line-offset width (5).
- State enum stays local to the module.
- No sub-module is needed. The line register with beat-indexed write/select is inline.

Test Plan:
- Read, back-to-back beats: addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. at cycles 2-5 -> mem_addr_o=0x0000_1220, line_resp_o at cycle 6, line_rdata_o = {0x44..,0x33..,0x22..,0x11..}.
- Write: line 0xDDDD…CCCC…BBBB…AAAA…, resp_i on 4 cycles -> mem_wdata_o presents AAAA, BBBB, CCCC, DDDD in order, mem_write_o high exactly until the 4th ack, one line_resp_o pulse.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o one cycle after the final ack, mem_read_o high throughout the gaps.
- Simultaneous read_i and write_i in IDLE -> WRITE performed, mem_read_o never asserted.
- rst pulsed asynchronously after 2 read beats -> all outputs 0 immediately (before next edge), no line_resp_o; a subsequent read completes normally.
- Write after read -> line_rdata_o is unchanged from the prior read value.
